// File: rtl/n4ddr_pkg.sv
// Shared definitions for the n4ddr SoC board-input path.
//   ps2_state_t    : PS/2 receive frame states
//   PS2_FRAME_BITS : bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_DATA_BITS  : payload bits per frame
//   odd_ones()     : 1 when data plus parity bit carry an odd number of ones
package n4ddr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  function automatic logic odd_ones(input logic [PS2_DATA_BITS-1:0] d,
                                    input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a level filter for one raw PS/2 pin.
// The filtered level only moves after FILTER_CYCLES consecutive synchronised
// samples disagree with it; any agreeing sample restarts the count.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (line resets to idle-high)
//   raw   in  asynchronous pin
//   level out filtered, synchronous line level
module ps2_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic       sync_p0;
  logic       sync_p1;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      cnt     <= 8'd0;
    end else begin
      // stage p0 -> p1: metastability settling
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // filter stage
      if (sync_p1 == level) begin
        cnt <= 8'd0;
      end else if (cnt == 8'(FILTER_CYCLES - 1)) begin
        level <= sync_p1;
        cnt   <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: conditions the keyboard clock/data pins,
// deframes 11-bit frames and queues scan-code bytes in a first-word
// fall-through FIFO with a valid/ready handshake.
// Optional feature: define PS2_RX_PARITY_EN to enforce odd parity; otherwise
// the parity bit is sampled and ignored.
// Ports:
//   CLK100MHZ   in  system clock
//   CPU_RESETN  in  asynchronous active-low reset
//   PS2_CLK     in  raw PS/2 clock pin
//   PS2_DATA    in  raw PS/2 data pin
//   rx_data     out FIFO head byte (holds last value when empty)
//   rx_valid    out FIFO not empty
//   rx_ready    in  consumer accepts head byte
//   frame_err   out 1-cycle pulse: bad start/stop bit or parity
//   timeout_err out 1-cycle pulse: frame abandoned after idle timeout
//   overflow    out 1-cycle pulse: good byte dropped, FIFO full
module ps2_rx
  import n4ddr_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  input  logic                     PS2_CLK,
  input  logic                     PS2_DATA,
  output logic [PS2_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     frame_err,
  output logic                     timeout_err,
  output logic                     overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  logic kclk;
  logic kdat;
  logic kclk_p1;
  logic fall;

  ps2_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .raw   (PS2_CLK),
    .level (kclk)
  );

  ps2_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filt (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .raw   (PS2_DATA),
    .level (kdat)
  );

  assign fall = kclk_p1 & ~kclk;

  ps2_state_t               state;
  logic [BW-1:0]            bit_cnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic [TW-1:0]            tcnt;
  logic                     parity_ok;
  logic                     push;
  logic                     bad;
  logic                     tmo;

`ifdef PS2_RX_PARITY_EN
  logic par_bit;
  assign parity_ok = odd_ones(shreg, par_bit);
`else
  assign parity_ok = 1'b1;
`endif

  // A stop-bit fall either commits the byte or flags the frame; a start
  // fall seeing data high is rejected without leaving IDLE.
  assign push = fall && (state == STOP) && kdat && parity_ok;
  assign bad  = fall && (((state == IDLE) && kdat) ||
                         ((state == STOP) && !(kdat && parity_ok)));
  // A fall in the same cycle restarts the idle window, so it wins.
  assign tmo  = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      kclk_p1     <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tcnt        <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef PS2_RX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      kclk_p1     <= kclk;
      frame_err   <= bad;
      timeout_err <= tmo;

      if ((state == IDLE) || fall || tmo) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (tmo) begin
        state   <= IDLE;
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!kdat) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            // LSB arrives first, so shifting right leaves d0 in bit 0.
            shreg   <= {kdat, shreg[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(PS2_DATA_BITS - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
`ifdef PS2_RX_PARITY_EN
            par_bit <= kdat;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // FIFO
  logic [PS2_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wptr;
  logic [PW-1:0]            rptr;
  logic [PW:0]              count;
  logic                     full;
  logic                     pop;
  logic                     wr;
  logic                     head_empty;

  assign rx_valid   = (count != '0);
  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign pop        = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot the full-FIFO push needs.
  assign wr         = push && (!full || pop);
  // True when no stored entry survives this cycle's pop.
  assign head_empty = pop ? (count == (PW+1)'(1)) : (count == '0);

  always_ff @(posedge CLK100MHZ) begin
    if (wr) begin
      mem[wptr] <= shreg;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      count <= count + (PW+1)'(wr) - (PW+1)'(pop);
      // Registered head keeps rx_data stable (last value) once drained.
      if (head_empty) begin
        if (wr) begin
          rx_data <= shreg;
        end
      end else begin
        rx_data <= mem[pop ? (rptr + PW'(1)) : rptr];
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: frame-level reference model (expected byte
// queue plus expected error/overflow tallies) driven by directed and random
// PS/2 frames.
module tb_ps2_rx;

  localparam int FILT  = 8;
  localparam int TOUT  = 400;
  localparam int DEPTH = 4;
  localparam int H     = 60;

  logic       clk = 1'b0;
  logic       CPU_RESETN;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       timeout_err;
  logic       overflow;

  ps2_rx #(
    .FILTER_CYCLES  (FILT),
    .TIMEOUT_CYCLES (TOUT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (CPU_RESETN),
    .PS2_CLK     (PS2_CLK),
    .PS2_DATA    (PS2_DATA),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int stop_cyc = 0;
  int last_lat = 0;

  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_tout = 0, exp_ovf = 0;
  int ferr_seen = 0, tout_seen = 0, ovf_seen = 0;
  int pops = 0, vhi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (CPU_RESETN) begin
      if (rx_valid)    vhi++;
      if (frame_err)   ferr_seen++;
      if (timeout_err) tout_seen++;
      if (overflow)    ovf_seen++;
      if (rx_valid && rx_ready) begin
        pops++;
        last_lat = cyc - stop_cyc;
        if (exp_q.size() == 0) check("pop_queue_depth", exp_q.size(), 1);
        else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame-level model: what the receiver should do with a completed frame.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    bit par_ok;
`ifdef PS2_RX_PARITY_EN
    par_ok = ((($countones(d) + int'(par)) % 2) == 1);
`else
    par_ok = 1'b1;
`endif
    if (stop && par_ok) begin
      if (exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back(d);
    end else begin
      exp_ferr++;
    end
  endtask

  // Sends the first nbits of a frame; a full frame (11 bits) updates the model.
  task automatic send_bits(input logic [7:0] d, input bit bad_par, input logic stop, input int nbits);
    logic [10:0] fr;
    logic par;
    par = (($countones(d) % 2) == 0) ^ bad_par;
    fr = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = fr[i];
      tick(H);
      PS2_CLK = 1'b0;
      if (i == 10) begin
        stop_cyc = cyc;
        model_frame(d, par, stop);
      end
      tick(H);
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
    tick(2 * H);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop);
    send_bits(d, bad_par, stop, 11);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ferr"}, ferr_seen, exp_ferr);
    check({tag, "_tout"}, tout_seen, exp_tout);
    check({tag, "_ovf"},  ovf_seen,  exp_ovf);
  endtask

  task automatic drain(input string tag);
    int t;
    rx_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick(1);
      t++;
    end
    tick(4);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_valid_low"}, rx_valid, 0);
  endtask

  initial begin
    int v0, p0;
    CPU_RESETN = 1'b0;
    PS2_CLK    = 1'b1;
    PS2_DATA   = 1'b1;
    rx_ready   = 1'b1;
    tick(5);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_tout", timeout_err, 0);
    check("rst_ovf", overflow, 0);
    CPU_RESETN = 1'b1;
    tick(20);

    // Good 8'h1C frame: one-cycle valid shortly after the stop-bit fall.
    v0 = vhi;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("lat_1c_in_range", (last_lat >= FILT + 2 && last_lat <= FILT + 5), 1);
    check("valid_width_1c", vhi - v0, 1);
    check("pops_1c", pops, 1);
    check_counts("good_1c");

    // Wrong parity.
    send_frame(8'h1C, 1'b1, 1'b1);
    drain("badpar");
    check_counts("badpar");

    // Bad start bit: single clock pulse with data high.
    PS2_DATA = 1'b1;
    tick(H);
    PS2_CLK = 1'b0;
    exp_ferr++;
    tick(H);
    PS2_CLK = 1'b1;
    tick(2 * H);
    check_counts("badstart");

    // Bad stop bit.
    send_frame(8'h5A, 1'b0, 1'b0);
    check_counts("badstop");

    // Truncated frame then long pause -> timeout, then a clean 8'hF0.
    send_bits(8'h33, 1'b0, 1'b1, 5);
    exp_tout++;
    tick(TOUT + 100);
    check_counts("timeout");
    send_frame(8'hF0, 1'b0, 1'b1);
    drain("after_tout");
    check_counts("after_tout");

    // FIFO overflow with consumer stalled.
    rx_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
    check("ovf_valid_held", rx_valid, 1);
    check("ovf_head", rx_data, 8'h01);
    check("ovf_queue", exp_q.size(), DEPTH);
    check_counts("ovf");
    drain("ovf");
    check("ovf_pops", pops - p0, 4);

    // Short glitches on the clock pin while idle.
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      PS2_CLK = 1'b0;
      tick(3);
      PS2_CLK = 1'b1;
      tick(25);
    end
    check("glitch_no_pop", pops, p0);
    check_counts("glitch");

    // Reset in the middle of a frame.
    send_bits(8'h96, 1'b0, 1'b1, 5);
    tick(10);
    CPU_RESETN = 1'b0;
    tick(3);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_tout", timeout_err, 0);
    check("midrst_ovf", overflow, 0);
    PS2_DATA = 1'b1;
    PS2_CLK  = 1'b1;
    tick(3);
    CPU_RESETN = 1'b1;
    tick(20);
    send_frame(8'hAA, 1'b0, 1'b1);
    drain("after_rst");
    check_counts("after_rst");

    // Random frames with random consumer stalls.
    for (int i = 0; i < 12; i++) begin
      rx_ready = 1'($urandom_range(0, 1));
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) != 0));
    end
    drain("random");
    check_counts("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host receiver for the n4ddr SoC. It takes the keyboard clock and data lines from the board's USB-HID bridge and synchronises and glitch-filters them. It deframes 11-bit PS/2 frames and delivers scan-code bytes through a small FIFO with a valid/ready handshake. This is the board-input counterpart to the seg7 display output path; the SoC reads scan codes here and can show them on seg7.

## Interface
- FILTER_CYCLES, default 8: consecutive agreeing samples needed before a filtered line changes level; range 2..255.
- TIMEOUT_CYCLES, default 20000: maximum idle cycles between falling edges inside a frame (200 us at 100 MHz).
- FIFO_DEPTH, default 4: number of byte entries; must be a power of two, at least 2.
- CLK100MHZ  in  1  system clock, 100 MHz; all logic on the rising edge.
- CPU_RESETN  in  1  reset, asynchronous, active-low.
- PS2_CLK  in  1  raw PS/2 clock pin, asynchronous to CLK100MHZ.
- PS2_DATA  in  1  raw PS/2 data pin, asynchronous to CLK100MHZ.
- rx_data  out  8  byte at the FIFO head; holds its last value while the FIFO is empty.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data; a pop occurs when rx_valid and rx_ready are both 1.
- frame_err  out  1  one-cycle pulse: bad start bit, bad stop bit, or parity error.
- timeout_err  out  1  one-cycle pulse: frame abandoned by timeout.
- overflow  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

## Operation
- Input conditioning:
  - Each pin passes through a 2-FF synchroniser, then a filter.
  - The filtered level changes only after FILTER_CYCLES consecutive synchronised samples differ from the current filtered level.
  - The filter counter clears on any sample equal to the filtered level.
- Falling edge (fall): filtered clock was 1 in the previous cycle and is 0 in this cycle. Data is sampled on fall from the filtered data line.
- Frame format, LSB first: start(0), d0..d7, odd parity, stop(1).
- State machine:
  - IDLE: on fall with data 0, go to DATA with bit_cnt=0. On fall with data 1, pulse frame_err and stay in IDLE.
  - DATA: on fall, shift the sampled bit into shreg[7] (right shift) and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, go to IDLE. If data is 1 and the parity check passes, push shreg. Otherwise pulse frame_err.
- Timeout:
  - The counter clears on every fall and in IDLE.
  - In any non-IDLE state, when the counter reaches TIMEOUT_CYCLES: go to IDLE, pulse timeout_err, discard the partial byte.
- FIFO behaviour:
  - First-word fall-through.
  - Push while full: the byte is dropped and overflow pulses. The exception is a pop in the same cycle: then both the pop and the push succeed and overflow does not pulse.
  - Push and pop when not full: occupancy is unchanged.
  - Pop while empty is ignored.
- Reset, asserted asynchronously at any time including mid-frame:
  - State goes to IDLE; bit_cnt, shreg and all counters go to 0.
  - Synchronisers and filtered lines go to 1.
  - FIFO becomes empty; rx_valid=0, rx_data=8'h00.
  - frame_err, timeout_err and overflow go to 0.

## Timing
- Pin edge to filtered edge: 2 + FILTER_CYCLES cycles.
- Fall detection: the cycle after the filtered clock goes 0.
- Stop-bit fall to rx_valid=1 with an empty FIFO: 1 cycle, because the push is registered.
- rx_data and rx_valid update on the cycle after a pop.
- Error pulses are exactly 1 cycle wide and registered, asserted in the cycle after the offending fall or the timeout.
- No combinational path from rx_ready to any output.

## Configuration
- PS2_RX_PARITY_EN defined:
  - The parity bit must make d0..d7 plus parity have an odd number of ones.
  - On mismatch the byte is not pushed and frame_err pulses.
- PS2_RX_PARITY_EN undefined: the parity bit is sampled and ignored. Only the start and stop bits can raise frame_err.

## Structure
- Shared package n4ddr_pkg holds:
  - typedef enum ps2_state_t {IDLE, DATA, PARITY, STOP};
  - localparams PS2_FRAME_BITS=11 and PS2_DATA_BITS=8.
- One sub-module, ps2_filter: 2-FF synchroniser plus filter, parameter FILTER_CYCLES, reset level 1. It is instantiated twice, once for clock and once for data.
- FIFO and frame FSM are inline in ps2_rx.

## Test plan
- Valid frame for 8'h1C (parity=0), with rx_ready=1 and 40 us clock period:
  - rx_valid=1 with rx_data=8'h1C exactly one cycle after the stop fall, for exactly 1 cycle.
  - No error pulses.
- Frame with wrong parity for 8'h1C (parity=1):
  - With PS2_RX_PARITY_EN: one frame_err pulse and rx_valid stays 0.
  - Without the macro: 8'h1C is delivered.
- Frame of 5 bits, then a 250 us clock pause: one timeout_err pulse, back in IDLE. A following valid 8'hF0 frame is received correctly.
- rx_ready=0, send 5 frames 8'h01..8'h05: FIFO holds 8'h01..8'h04 and one overflow pulse occurs on the 5th. Then rx_ready=1 drains 01,02,03,04 in order.
- 3-cycle glitch pulses on PS2_CLK during IDLE: no state change and no errors.
- CPU_RESETN asserted after d3 of a frame, then released:
  - All outputs at their reset values during reset.
  - The next full frame 8'hAA is received correctly.
